// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared divider state encodings and handshake constants
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

endpackage

// File: rtl/div_seq_unit_step.sv
// rtl/div_seq_unit_step.sv - one restoring-division iteration: shift left, trial-subtract
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]   work_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH:0]   work_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   diff;

    assign shifted = work_i << 1;
    assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_i};

    // A borrow out of the top bit means the trial went negative: keep the shifted value.
    assign work_o = diff[WIDTH] ? shifted
                                : {diff, shifted[WIDTH-1:1], 1'b1};

endmodule

// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - iterative radix-2 restoring divider; DIV_EARLY_OUT_EN enables |op1|<|op2| shortcut
module div_seq_unit
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH:0]    work_q, work_d;
    logic [WIDTH-1:0]    divisor_q, divisor_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                ready_q, ready_d;

    logic [WIDTH-1:0]    abs_op1, abs_op2;
    logic [2*WIDTH:0]    step_out;
    logic [WIDTH-1:0]    quot_raw, rem_raw, quot_fix, rem_fix;

    assign abs_op1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs_op2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    div_step #(.WIDTH(WIDTH)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_out)
    );

    // Negating 0x80000000 yields itself, so the most-negative / -1 case wraps naturally.
    assign quot_raw = step_out[WIDTH-1:0];
    assign rem_raw  = step_out[2*WIDTH-1:WIDTH];
    assign quot_fix = neg_quot_q ? -quot_raw : quot_raw;
    assign rem_fix  = neg_rem_q  ? -rem_raw  : rem_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivFree;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else
`ifdef DIV_EARLY_OUT_EN
                    if (abs_op1 < abs_op2) begin
                        state_d  = DivEnd;
                        result_d = {opdata1_i, {WIDTH{1'b0}}};
                    end else
`endif
                    begin
                        state_d    = DivOn;
                        cnt_d      = '0;
                        work_d     = {{(WIDTH+1){1'b0}}, abs_op1};
                        divisor_d  = abs_op2;
                        neg_quot_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d  = signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
            end
            DivByZero: begin
                state_d  = annul_i ? DivFree : DivEnd;
                result_d = '0;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                    cnt_d   = '0;
                end else begin
                    work_d = step_out;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DivEnd;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else begin
                    ready_d = DivResultReady;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// tb/tb_div_seq_unit.sv - randomized self-checking bench for div_seq_unit against an arithmetic model
module tb_div_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_seq_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_latency(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (b == 32'd0) return 2;
        ma = s ? longint'($signed(a)) : longint'({32'd0, a});
        mb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Called right after the inputs are driven; the next edge samples start.
    task automatic await_result(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
        int lat;
        @(posedge clk); #1;
        lat = 0;
        while (ready !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(ref_latency(s, a, b)));
        check({tag, "_res"}, result, ref_div(s, a, b));
    endtask

    task automatic run_op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_extra);
        signed_div = s; op1 = a; op2 = b; start = 1'b1;
        await_result(tag, s, a, b);
        if (hold_extra) begin
            @(posedge clk); #1;
            check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
            check({tag, "_hold_res"}, result, ref_div(s, a, b));
        end
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        check({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        bit          rs;
        logic [31:0] ra, rb;
        int          seen;

        rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 64'(ready), 64'd0);
        check("reset_res", result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("u100_7",   1'b0, 32'd100,        32'd7,          1'b1);
        run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'h2,          1'b0);
        run_op("s_7_m2",   1'b1, 32'd7,          32'hFFFF_FFFE,  1'b0);
        run_op("s_div0",   1'b1, 32'd5,          32'd0,          1'b0);
        run_op("s_minm1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          1'b0);
        run_op("u3_10",    1'b0, 32'd3,          32'd10,         1'b0);

        // Flush at iteration 10: no ready, back to idle, next op is clean.
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
        seen = 0;
        repeat (11) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        repeat (40) begin
            if (ready) seen++;
            @(posedge clk); #1;
        end
        check("annul_no_rdy", 64'(seen), 64'd0);
        check("annul_res", result, 64'd0);
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 1'b0);

        // Reset at iteration 15 with start held; the held start restarts the op.
        signed_div = 1'b1; op1 = 32'hFFFF_FC18; op2 = 32'd33; start = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_rdy", 64'(ready), 64'd0);
        check("rst_mid_res", result, 64'd0);
        rst = 1'b0;
        await_result("rst_restart", 1'b1, 32'hFFFF_FC18, 32'd33);
        start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = (i % 10 == 0) ? 32'd0 : $urandom;
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rnd%0d", i), rs, ra, rb, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
